pipe_shifter: RTL and testbench

- Parametrised, pipelined successor to the ALU's single-function arithmetic right shifter.
- One unit provides SLL, SRL and SRA (ROR optional) with a valid/ready handshake on input and output, and a configurable number of register stages.
- Flags Z/V/N match the ALU flag convention.
- Sits beside the ALU in EX; feeds the EX/MEM result mux and stalls via in_ready.

---
 rtl/shifter_pkg.sv | 33 +++
 rtl/shift_stage.sv | 79 +++++++
 rtl/pipe_shifter.sv | 107 ++++++++++
 tb/tb_pipe_shifter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared op encodings, per-stage control payload and level-split helpers for pipe_shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Data, amount and tag are width-parametrised, so they travel beside this struct.
  typedef struct packed {
    logic valid;
    op_e  op;
    logic ovr;
  } stage_ctrl_t;

  function automatic int lvls_per_stage(input int width, input int stages);
    return ($clog2(width) + stages - 1) / stages;
  endfunction

  function automatic int stage_first_lvl(input int width, input int stages, input int k);
    return k * lvls_per_stage(width, stages);
  endfunction

  function automatic int stage_num_lvl(input int width, input int stages, input int k);
    int rem;
    rem = $clog2(width) - stage_first_lvl(width, stages, k);
    if (rem < 0) rem = 0;
    return (rem < lvls_per_stage(width, stages)) ? rem : lvls_per_stage(width, stages);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One register stage of pipe_shifter: applies a contiguous run of binary shift levels.
// Rotate levels exist only when PIPE_SHIFTER_ROR_EN is defined.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1,
  parameter bit IS_LAST   = 1'b0,
  localparam int AMT_W    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ready,
  input  stage_ctrl_t       up_ctrl,
  input  logic [AMT_W-1:0]  up_amt,
  input  logic [WIDTH-1:0]  up_data,
  input  logic [TAG_W-1:0]  up_tag,
  output stage_ctrl_t       ctrl,
  output logic [AMT_W-1:0]  amt,
  output logic [WIDTH-1:0]  data,
  output logic [TAG_W-1:0]  tag
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] result;

  always_comb begin
    shifted = up_data;
    for (int l = FIRST_LVL; l < FIRST_LVL + NUM_LVL; l++) begin
      if (up_amt[l]) begin
        case (up_ctrl.op)
          OP_SLL: shifted = shifted << (1 << l);
          OP_SRL: shifted = shifted >> (1 << l);
          OP_SRA: shifted = $unsigned($signed(shifted) >>> (1 << l));
`ifdef PIPE_SHIFTER_ROR_EN
          OP_ROR: shifted = (shifted >> (1 << l)) | (shifted << (WIDTH - (1 << l)));
`endif
          default: ;
        endcase
      end
    end

    // Over-range fill is applied last; SRA levels never disturb the sign bit.
    result = shifted;
    if (IS_LAST) begin
      if (up_ctrl.op == OP_ROR) begin
`ifndef PIPE_SHIFTER_ROR_EN
        result = '0;
`endif
      end else if (up_ctrl.ovr) begin
        result = (up_ctrl.op == OP_SRA) ? {WIDTH{up_data[WIDTH-1]}} : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
      amt  <= '0;
      data <= '0;
      tag  <= '0;
    end else if (flush) begin
      ctrl.valid <= 1'b0;
    end else if (ready) begin
      ctrl.valid <= up_ctrl.valid;
      if (up_ctrl.valid) begin
        ctrl.op  <= up_ctrl.op;
        ctrl.ovr <= up_ctrl.ovr;
        amt      <= up_amt;
        data     <= result;
        tag      <= up_tag;
      end
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined SLL/SRL/SRA shifter with valid/ready on both sides and a tag sideband.
// Define PIPE_SHIFTER_ROR_EN to add rotate-right on op 11; otherwise op 11 reports unsupported.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_shamt,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_z,
  output logic             out_v,
  output logic             out_n,
  output logic             busy
);

  localparam int AMT_W = $clog2(WIDTH);

  stage_ctrl_t        head_ctrl;
  stage_ctrl_t        ctrl_q [PIPE_STAGES];
  logic [AMT_W-1:0]   amt_q  [PIPE_STAGES];
  logic [WIDTH-1:0]   data_q [PIPE_STAGES];
  logic [TAG_W-1:0]   tag_q  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_v;
  logic [PIPE_STAGES:0]   ready_v;

  // A stage may load when it is empty or the stage below is taking its op.
  always_comb begin
    ready_v[PIPE_STAGES] = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      ready_v[k] = !valid_v[k] || ready_v[k+1];
    end
  end

  assign in_ready  = ready_v[0] && !flush;
  assign head_ctrl = '{valid: in_valid && in_ready,
                       op:    op_e'(in_op),
                       ovr:   |in_shamt[WIDTH-1:AMT_W]};

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    stage_ctrl_t      up_ctrl;
    logic [AMT_W-1:0] up_amt;
    logic [WIDTH-1:0] up_data;
    logic [TAG_W-1:0] up_tag;

    if (k == 0) begin : g_head
      assign up_ctrl = head_ctrl;
      assign up_amt  = in_shamt[AMT_W-1:0];
      assign up_data = in_data;
      assign up_tag  = in_tag;
    end else begin : g_body
      assign up_ctrl = ctrl_q[k-1];
      assign up_amt  = amt_q[k-1];
      assign up_data = data_q[k-1];
      assign up_tag  = tag_q[k-1];
    end

    shift_stage #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .FIRST_LVL (stage_first_lvl(WIDTH, PIPE_STAGES, k)),
      .NUM_LVL   (stage_num_lvl(WIDTH, PIPE_STAGES, k)),
      .IS_LAST   (k == PIPE_STAGES - 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .ready   (ready_v[k]),
      .up_ctrl (up_ctrl),
      .up_amt  (up_amt),
      .up_data (up_data),
      .up_tag  (up_tag),
      .ctrl    (ctrl_q[k]),
      .amt     (amt_q[k]),
      .data    (data_q[k]),
      .tag     (tag_q[k])
    );

    assign valid_v[k] = ctrl_q[k].valid;
  end

  assign busy      = |valid_v;
  assign out_valid = valid_v[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign out_n     = 1'b0;
  // Flags are qualified by out_valid so they read 0 out of reset.
  assign out_z     = out_valid && (out_data == '0);
`ifdef PIPE_SHIFTER_ROR_EN
  assign out_v     = 1'b0;
`else
  assign out_v     = out_valid && (ctrl_q[PIPE_STAGES-1].op == OP_ROR);
`endif

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter (WIDTH=32, PIPE_STAGES=2); rotate expectations follow PIPE_SHIFTER_ROR_EN.
module tb_pipe_shifter;

  localparam int WIDTH       = 32;
  localparam int PIPE_STAGES = 2;
  localparam int TAG_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [WIDTH-1:0] in_shamt = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_z, out_v, out_n, busy;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_shamt(in_shamt), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_z(out_z), .out_v(out_v), .out_n(out_n), .busy(busy)
  );

  localparam int NV = 12;
  logic [1:0]  v_op    [NV] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd2};
  logic [31:0] v_data  [NV] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h00000001,
                                32'h000000F0, 32'h12345678, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                32'h7FFFFFF0, 32'h80000000, 32'h0000ABCD, 32'h80000000};
  logic [31:0] v_shamt [NV] = '{32'd4, 32'd40, 32'd32, 32'd31, 32'd0, 32'd0, 32'h100, 32'd31,
                                32'd33, 32'd31, 32'd16, 32'hFFFFFFFF};
  logic [31:0] v_exp   [NV] = '{32'hF8000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                                32'h000000F0, 32'h12345678, 32'h00000000, 32'h00000000,
                                32'h00000000, 32'h00000001, 32'hABCD0000, 32'hFFFFFFFF};

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({out_valid, busy, out_z, out_v, out_n} !== 5'b0) begin
      miss_cnt++;
      $display("FAIL reset_flags got valid/busy/z/v/n=%b want 00000", {out_valid, busy, out_z, out_v, out_n});
    end
    vec_cnt++;
    if ({out_data, out_tag} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_data got data=%h tag=%h want 0", out_data, out_tag);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_shift_ops();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = v_op[i]; in_data = v_data[i];
      in_shamt = v_shamt[i]; in_tag = 4'(i + 1);
      #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin
        miss_cnt++;
        $display("FAIL ops[%0d]_in_ready got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      vec_cnt++;
      if (out_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL ops[%0d]_early_valid got %b want 0", i, out_valid);
      end
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b1 || out_data !== v_exp[i] || out_tag !== 4'(i + 1)) begin
        miss_cnt++;
        $display("FAIL ops[%0d]_result got valid=%b data=%h tag=%h want 1 %h %h",
                 i, out_valid, out_data, out_tag, v_exp[i], 4'(i + 1));
      end
      vec_cnt++;
      if (out_z !== (v_exp[i] == 32'h0) || out_v !== 1'b0 || out_n !== 1'b0) begin
        miss_cnt++;
        $display("FAIL ops[%0d]_flags got z=%b v=%b n=%b want %b 0 0",
                 i, out_z, out_v, out_n, (v_exp[i] == 32'h0));
      end
    end
  endtask

  task automatic test_ror();
    logic [31:0] shamts [3];
    logic [31:0] exp_d  [3];
    logic        exp_v;
    shamts = '{32'd8, 32'd40, 32'd0};
`ifdef PIPE_SHIFTER_ROR_EN
    exp_d = '{32'h78123456, 32'h78123456, 32'h12345678};
    exp_v = 1'b0;
`else
    exp_d = '{32'h0, 32'h0, 32'h0};
    exp_v = 1'b1;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b11; in_data = 32'h12345678;
      in_shamt = shamts[i]; in_tag = 4'(8 + i);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_tag !== 4'(8 + i)) begin
        miss_cnt++;
        $display("FAIL ror[%0d]_result got valid=%b data=%h tag=%h want 1 %h %h",
                 i, out_valid, out_data, out_tag, exp_d[i], 4'(8 + i));
      end
      vec_cnt++;
      if (out_v !== exp_v || out_z !== (exp_d[i] == 32'h0) || out_n !== 1'b0) begin
        miss_cnt++;
        $display("FAIL ror[%0d]_flags got v=%b z=%b n=%b want %b %b 0",
                 i, out_v, out_z, out_n, exp_v, (exp_d[i] == 32'h0));
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 5) begin
        vec_cnt++;
        if (out_valid !== 1'b1 || out_tag !== 4'(3 + i) || out_data !== (32'h1 << (3 + i))) begin
          miss_cnt++;
          $display("FAIL b2b[%0d] got valid=%b tag=%h data=%h want 1 %h %h",
                   i - 2, out_valid, out_tag, out_data, 4'(3 + i), 32'h1 << (3 + i));
        end
      end
      if (i == 5) begin
        vec_cnt++;
        if (out_valid !== 1'b0) begin
          miss_cnt++;
          $display("FAIL b2b_tail_valid got %b want 0", out_valid);
        end
      end
      if (i < 3) begin
        in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1;
        in_shamt = 32'(5 + i); in_tag = 4'(5 + i);
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
          miss_cnt++;
          $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    int nxt;
    exp_d = '{32'h78000000, 32'h3C000000, 32'h1E000000, 32'h0F000000};
    nxt = 0;
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (s >= 2) begin
        vec_cnt++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_data !== exp_d[0]) begin
          miss_cnt++;
          $display("FAIL bp_hold[%0d] got valid=%b tag=%h data=%h want 1 1 %h",
                   s, out_valid, out_tag, out_data, exp_d[0]);
        end
      end
      in_valid = 1'b1; in_op = 2'b01; in_data = 32'hF0000000;
      in_shamt = 32'(nxt + 1); in_tag = 4'(nxt + 1);
      #1;
      vec_cnt++;
      if (in_ready !== (nxt < 2)) begin
        miss_cnt++;
        $display("FAIL bp_in_ready[%0d] got %b want %b", s, in_ready, (nxt < 2));
      end
      if (in_ready) nxt++;
    end
    vec_cnt++;
    if (busy !== 1'b1) begin
      miss_cnt++;
      $display("FAIL bp_busy got %b want 1", busy);
    end
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      if (d < 4) begin
        vec_cnt++;
        if (out_valid !== 1'b1 || out_tag !== 4'(d + 1) || out_data !== exp_d[d]) begin
          miss_cnt++;
          $display("FAIL bp_drain[%0d] got valid=%b tag=%h data=%h want 1 %h %h",
                   d, out_valid, out_tag, out_data, 4'(d + 1), exp_d[d]);
        end
      end else begin
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          miss_cnt++;
          $display("FAIL bp_empty got valid=%b busy=%b want 0 0", out_valid, busy);
        end
      end
      out_ready = 1'b1;
      if (nxt < 4) begin
        in_valid = 1'b1; in_shamt = 32'(nxt + 1); in_tag = 4'(nxt + 1);
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
          miss_cnt++;
          $display("FAIL bp_drain_in_ready[%0d] got %b want 1", d, in_ready);
        end
        if (in_ready) nxt++;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b00; in_data = 32'h3;
      in_shamt = 32'd1; in_tag = 4'(9 + i);
    end
    @(negedge clk);
    flush = 1'b1; in_tag = 4'd11;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      miss_cnt++;
      $display("FAIL flush_cycle got in_ready=%b busy=%b valid=%b want 0 1 1", in_ready, busy, out_valid);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL flush_clear got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL flush_stale[%0d] got valid=%b tag=%h want 0", i, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b00; in_data = 32'h3;
      in_shamt = 32'd4; in_tag = 4'(12 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h30 || out_tag !== 4'd12) begin
      miss_cnt++;
      $display("FAIL rst_pre got valid=%b data=%h tag=%h want 1 30 c", out_valid, out_data, out_tag);
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({out_valid, busy, out_z, out_v, out_n} !== 5'b0 || out_data !== '0 || out_tag !== '0) begin
      miss_cnt++;
      $display("FAIL rst_async got valid/busy/z/v/n=%b data=%h tag=%h want 0",
               {out_valid, busy, out_z, out_v, out_n}, out_data, out_tag);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0) begin
        miss_cnt++;
        $display("FAIL rst_stale[%0d] got valid=%b want 0", i, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b01; in_data = 32'hF0; in_shamt = 32'd4; in_tag = 4'd15;
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL rst_fresh_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h0F || out_tag !== 4'd15) begin
      miss_cnt++;
      $display("FAIL rst_fresh got valid=%b data=%h tag=%h want 1 0f f", out_valid, out_data, out_tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shift_ops();
    test_ror();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
